// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-side branch predictor and the PC select logic.
//   - 2-bit confidence counter encodings
//   - sequential PC increment
//   - PC source select codes consumed by the fetch PC mux
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam int PC_INC = 4;

  typedef enum logic [1:0] {
    PCSRC_SEQ      = 2'b00,
    PCSRC_BRANCH   = 2'b01,
    PCSRC_JUMP     = 2'b10,
    PCSRC_REDIRECT = 2'b11
  } pcsrc_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter step (combinational).
// Ports:
//   ctr_in  : current counter value
//   up      : 1 = step towards strongly taken, 0 = towards strongly not taken
//   ctr_out : next counter value, held at the end points
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_in,
  input  logic       up,
  output logic [1:0] ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    if (up) begin
      if (ctr_in != CTR_ST) ctr_out = ctr_in + 2'd1;
    end else begin
      if (ctr_in != CTR_SNT) ctr_out = ctr_in - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit confidence counters,
// mispredict detection against the prediction carried down to EX, and
// saturating resolution statistics.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   if_pc                        : fetch PC being looked up
//   pred_taken, pred_target      : combinational prediction for if_pc
//   ex_branch, ex_pc, ex_taken,
//   ex_target                    : resolving conditional branch and its real outcome
//   ex_pred_taken, ex_pred_target: prediction that travelled with that branch
//   mispredict, correct_pc       : combinational flush/redirect request
//   stat_branches, stat_miss     : saturating resolved-branch / mispredict counts
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              ex_branch,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_taken,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  output logic              mispredict,
  output logic [PC_W-1:0]   correct_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_miss
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

  logic [ENTRIES-1:0] valid_mem;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [PC_W-1:0]    target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic [1:0]       ctr_next;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

  // Lookup reads the table as it stands before this cycle's update (no bypass).
  assign if_hit = valid_mem[if_idx] && (tag_mem[if_idx] == if_tag);
  assign ex_hit = valid_mem[ex_idx] && (tag_mem[ex_idx] == ex_tag);

  // The table may still hold pre-reset contents during the first reset cycle,
  // so the prediction is forced to fall-through while rst is high.
  assign pred_taken  = !rst && if_hit && ctr_mem[if_idx][1];
  assign pred_target = pred_taken ? target_mem[if_idx] : if_pc + PC_STEP;

  assign mispredict = ex_branch &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
  assign correct_pc = ex_taken ? ex_target : ex_pc + PC_STEP;

  sat_counter2 u_ctr (
    .ctr_in  (ctr_mem[ex_idx]),
    .up      (ex_taken),
    .ctr_out (ctr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_mem     <= '0;
      stat_branches <= '0;
      stat_miss     <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
        ctr_mem[i]    <= CTR_WNT;
      end
    end else if (ex_branch) begin
      if (ex_hit) begin
        ctr_mem[ex_idx] <= ctr_next;
        if (ex_taken) target_mem[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        // Allocation evicts whatever aliased into this slot.
        valid_mem[ex_idx]  <= 1'b1;
        tag_mem[ex_idx]    <= ex_tag;
        target_mem[ex_idx] <= ex_target;
        ctr_mem[ex_idx]    <= CTR_WT;
      end
      if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
      if (mispredict && (stat_miss != '1)) stat_miss <= stat_miss + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int ENT    = 16;
  localparam int SW     = 8;
  localparam int SATMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   if_pc = '0;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          ex_branch = 1'b0;
  logic [31:0]   ex_pc = '0;
  logic          ex_taken = 1'b0;
  logic [31:0]   ex_target = '0;
  logic          ex_pred_taken = 1'b0;
  logic [31:0]   ex_pred_target = '0;
  logic          mispredict;
  logic [31:0]   correct_pc;
  logic [SW-1:0] stat_branches;
  logic [SW-1:0] stat_miss;

  branch_predictor #(.ENTRIES(ENT), .PC_W(32), .STAT_W(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_branch      (ex_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .correct_pc     (correct_pc),
    .stat_branches  (stat_branches),
    .stat_miss      (stat_miss)
  );

  always #5 clk = ~clk;

  // Reference model: each slot remembers which branch owns it and a
  // confidence level 0..3 (taken when >= 2).
  bit          m_valid [ENT];
  logic [31:0] m_owner [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_conf  [ENT];
  int          m_branches, m_miss;

  typedef struct {
    bit          pt;
    logic [31:0] ptg;
    bit          mp;
    logic [31:0] cp;
    int          sb;
    int          sm;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic int slot_of(logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic bit owns(logic [31:0] pc);
    int s = slot_of(pc);
    return m_valid[s] && ((m_owner[s] / (4 * ENT)) == (pc / (4 * ENT)));
  endfunction

  task automatic model_pred(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    t  = owns(pc) && (m_conf[slot_of(pc)] >= 2);
    tg = t ? m_tgt[slot_of(pc)] : pc + 32'd4;
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0;
      m_owner[i] = '0;
      m_tgt[i]   = '0;
      m_conf[i]  = 1;
    end
    m_branches = 0;
    m_miss     = 0;
  endtask

  task automatic step(input bit chk, input bit r, input logic [31:0] ipc,
                      input bit eb, input logic [31:0] epc, input bit et,
                      input logic [31:0] etg, input bit ept, input logic [31:0] eptg);
    exp_t e;
    int   s;
    @(posedge clk);
    #1;
    rst = r; if_pc = ipc; ex_branch = eb; ex_pc = epc; ex_taken = et;
    ex_target = etg; ex_pred_taken = ept; ex_pred_target = eptg;
    model_pred(ipc, e.pt, e.ptg);
    if (r) begin
      e.pt  = 0;
      e.ptg = ipc + 32'd4;
    end
    e.mp = eb && ((et != ept) || (et && (etg != eptg)));
    e.cp = et ? etg : epc + 32'd4;
    e.sb = m_branches;
    e.sm = m_miss;
    if (chk) exp_q.push_back(e);
    if (r) model_reset();
    else if (eb) begin
      s = slot_of(epc);
      if (owns(epc)) begin
        if (et) begin
          m_conf[s] = (m_conf[s] == 3) ? 3 : m_conf[s] + 1;
          m_tgt[s]  = etg;
        end else begin
          m_conf[s] = (m_conf[s] == 0) ? 0 : m_conf[s] - 1;
        end
      end else if (et) begin
        m_valid[s] = 1;
        m_owner[s] = epc;
        m_tgt[s]   = etg;
        m_conf[s]  = 2;
      end
      if (m_branches < SATMAX) m_branches++;
      if (e.mp && m_miss < SATMAX) m_miss++;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("pred_taken", {31'b0, pred_taken}, {31'b0, e.pt});
      cmp("pred_target", pred_target, e.ptg);
      cmp("mispredict", {31'b0, mispredict}, {31'b0, e.mp});
      if (e.mp) cmp("correct_pc", correct_pc, e.cp);
      cmp("stat_branches", {{(32-SW){1'b0}}, stat_branches}, 32'(e.sb));
      cmp("stat_miss", {{(32-SW){1'b0}}, stat_miss}, 32'(e.sm));
    end
  end

  localparam logic [31:0] A = 32'h40;

  initial begin
    bit          t;
    logic [31:0] tg, ipc, epc, etg;
    bit          eb, et, r;
    int          guard;

    model_reset();
    step(0, 1, A, 0, 0, 0, 0, 0, 0);
    step(0, 1, A, 0, 0, 0, 0, 0, 0);

    // Directed: cold lookup, not-taken resolve, allocation, counter walk.
    step(1, 0, A, 0, 0, 0, 0, 0, 0);
    step(1, 0, A, 1, A, 0, 0, 0, A + 4);
    step(1, 0, A, 1, A, 1, 32'h100, 0, A + 4);
    step(1, 0, A, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, A, 1, A, 1, 32'h100, 1, 32'h100);
    step(1, 0, A, 1, A, 0, 0, 1, 32'h100);
    step(1, 0, A, 1, A, 0, 0, 1, 32'h100);
    step(1, 0, A, 0, 0, 0, 0, 0, 0);
    // Aliasing eviction by 0x80 (same slot).
    step(1, 0, A, 1, 32'h80, 1, 32'h300, 0, 32'h84);
    step(1, 0, A, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h80, 0, 0, 0, 0, 0, 0);
    // Wrong target and wrong direction.
    step(1, 0, A, 1, A, 1, 32'h100, 0, A + 4);
    step(1, 0, A, 1, A, 1, 32'h200, 1, 32'h100);
    step(1, 0, A, 1, A, 0, 0, 1, 32'h200);
    // Same-cycle lookup of the slot being updated sees old contents.
    step(1, 0, 32'hC0, 1, 32'hC0, 1, 32'h400, 0, 32'hC4);
    step(1, 0, 32'hC0, 0, 0, 0, 0, 0, 0);
    // +4 wraps silently.
    step(1, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h10);

    // Randomised traffic over a small PC pool so slots alias often.
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 99) == 0);
      ipc = 32'($urandom_range(0, 127)) * 4;
      epc = 32'($urandom_range(0, 127)) * 4;
      eb  = $urandom_range(0, 1) == 1;
      et  = $urandom_range(0, 1) == 1;
      etg = 32'($urandom_range(0, 255)) * 4;
      if ($urandom_range(0, 2) != 0) model_pred(epc, t, tg);
      else begin
        t  = $urandom_range(0, 1) == 1;
        tg = 32'($urandom_range(0, 255)) * 4;
      end
      step(1, r, ipc, eb, epc, et, etg, t, tg);
    end

    // Statistics saturation.
    step(1, 1, A, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < SATMAX + 6; n++) step(1, 0, A, 1, 32'h44, 1, 32'h500, 0, 32'h48);
    step(1, 0, A, 0, 0, 0, 0, 0, 0);
    // Mid-stream reset with a branch present: no update, everything forgotten.
    step(1, 0, 32'h44, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h44, 1, A, 1, 32'h100, 0, A + 4);
    step(1, 0, 32'h44, 0, 0, 0, 0, 0, 0);
    step(1, 0, A, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
